// File: rtl/la_input_router.sv
`default_nettype none
// ============================================================================
// la_input_router -- routes masked LA input to one team slot, blanking on
// every select change. Rev 1.0
// ============================================================================
module la_input_router #(
  parameter int NUM_TEAMS    = 13,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [3:0]           la_sel,
  input  logic [127:0]         la_data_in,
  input  logic [127:0]         la_oenb,
  output logic [127:0]         team_la_in [NUM_TEAMS-1:0],
  output logic [NUM_TEAMS-1:0] team_la_valid,
  output logic [3:0]           active_sel,
  output logic                 switching,
  output logic [7:0]           sel_changes
);

  localparam logic [7:0] C_RELOAD = 8'(BLANK_CYCLES - 1);
  localparam logic [3:0] C_NONE   = 4'hF;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PARKED = 2'd2
  } state_t;

  state_t               r_state;
  logic [127:0]         r_dat_q;
  logic [3:0]           r_sel_q;
  logic [3:0]           r_pending_sel;
  logic [3:0]           r_active_sel;
  logic [7:0]           r_cnt;
  logic [7:0]           r_sel_changes;
  logic                 r_switching;
  logic [NUM_TEAMS-1:0] r_valid;
  logic [127:0]         r_team [NUM_TEAMS-1:0];

  logic [3:0]           w_target;
  logic                 w_pending_ok;

  // PARKED remembers its requested index in pending_sel, so it is the target there
  assign w_target     = (r_state == ST_ACTIVE) ? r_active_sel : r_pending_sel;
  assign w_pending_ok = ({28'd0, r_pending_sel} < 32'(NUM_TEAMS));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state       <= ST_BLANK;
      r_dat_q       <= '0;
      r_sel_q       <= '0;
      r_pending_sel <= '0;
      r_active_sel  <= C_NONE;
      r_cnt         <= C_RELOAD;
      r_sel_changes <= '0;
      r_switching   <= 1'b1;
      r_valid       <= '0;
      for (int t = 0; t < NUM_TEAMS; t++) r_team[t] <= '0;
    end else begin
      r_dat_q <= la_data_in & ~la_oenb;
      r_sel_q <= la_sel;
      r_valid <= '0;
      for (int t = 0; t < NUM_TEAMS; t++) r_team[t] <= '0;

      case (r_state)
        ST_ACTIVE, ST_PARKED: begin
          if (r_sel_q != w_target) begin
            r_state       <= ST_BLANK;
            r_pending_sel <= r_sel_q;
            r_cnt         <= C_RELOAD;
            r_active_sel  <= C_NONE;
            r_switching   <= 1'b1;
            if (r_sel_changes != 8'hFF) r_sel_changes <= r_sel_changes + 8'd1;
          end else if (r_state == ST_ACTIVE) begin
            for (int t = 0; t < NUM_TEAMS; t++) begin
              if (r_active_sel == 4'(t)) begin
                r_team[t]  <= r_dat_q;
                r_valid[t] <= 1'b1;
              end
            end
          end
        end

        ST_BLANK: begin
          if (r_sel_q != r_pending_sel) begin
            r_pending_sel <= r_sel_q;
            r_cnt         <= C_RELOAD;
          end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (w_pending_ok) begin
            // the exit cycle already delivers the current dat_q
            r_state      <= ST_ACTIVE;
            r_active_sel <= r_pending_sel;
            r_switching  <= 1'b0;
            for (int t = 0; t < NUM_TEAMS; t++) begin
              if (r_pending_sel == 4'(t)) begin
                r_team[t]  <= r_dat_q;
                r_valid[t] <= 1'b1;
              end
            end
          end else begin
            r_state     <= ST_PARKED;
            r_switching <= 1'b0;
          end
        end

        default: begin
          r_state       <= ST_BLANK;
          r_pending_sel <= '0;
          r_cnt         <= C_RELOAD;
          r_active_sel  <= C_NONE;
          r_switching   <= 1'b1;
        end
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_TEAMS; g++) begin : g_team_out
      assign team_la_in[g] = r_team[g];
    end
  endgenerate

  assign team_la_valid = r_valid;
  assign active_sel    = r_active_sel;
  assign switching     = r_switching;
  assign sel_changes   = r_sel_changes;

endmodule
`default_nettype wire

// File: doc/la_input_router.md
LA_INPUT_ROUTER -- requirements
Module: la_input_router

Interface
REQ-001 The block SHALL have parameter NUM_TEAMS, default 13, meaning the number of team slots (indices 0..NUM_TEAMS-1).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 4, meaning the guard interval in cycles on a select change; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port nrst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port la_sel, input, 4 bits: requested team index.
REQ-006 The block SHALL have port la_data_in, input, 128 bits: host-driven logic-analyzer data.
REQ-007 The block SHALL have port la_oenb, input, 128 bits: per-bit enable, active-low; bit=1 means the host is not driving that bit.
REQ-008 The block SHALL have port team_la_in, output, unpacked array [NUM_TEAMS-1:0] of 128 bits: per-team routed data.
REQ-009 The block SHALL have port team_la_valid, output, NUM_TEAMS bits: one-hot valid for the routed team.
REQ-010 The block SHALL have port active_sel, output, 4 bits: currently routed index; 4'hF when none is routed.
REQ-011 The block SHALL have port switching, output, 1 bit: high while in state BLANK.
REQ-012 The block SHALL have port sel_changes, output, 8 bits: count of accepted select changes, saturating.

Function
REQ-013 Stage 1 SHALL register dat_q = la_data_in & ~la_oenb and sel_q = la_sel every cycle.
REQ-014 The FSM SHALL have exactly three states: BLANK, ACTIVE and PARKED, plus registers pending_sel (4b) and cnt (8b).
REQ-015 In ACTIVE, team_la_in[active_sel] SHALL be registered from dat_q (2-cycle latency from la_data_in), and every other team_la_in entry SHALL be 0.
REQ-016 In ACTIVE, team_la_valid SHALL be one-hot at active_sel.
REQ-017 In BLANK and in PARKED, every team_la_in entry SHALL be 0 and team_la_valid SHALL be 0.
REQ-018 In PARKED, active_sel SHALL be 4'hF.
REQ-019 In ACTIVE or PARKED, when sel_q differs from the routed target, the next state SHALL be BLANK with pending_sel=sel_q, cnt=BLANK_CYCLES-1, and sel_changes incremented, saturating at 255.
- The routed target is active_sel in ACTIVE and the last pending_sel in PARKED.
REQ-020 In BLANK, when sel_q differs from pending_sel, the block SHALL set pending_sel=sel_q and reload cnt=BLANK_CYCLES-1; sel_changes SHALL NOT increment.
REQ-021 In BLANK, otherwise, while cnt is nonzero the block SHALL decrement cnt.
REQ-022 In BLANK with cnt==0 and sel_q==pending_sel, the next state SHALL be ACTIVE with active_sel=pending_sel when pending_sel < NUM_TEAMS, else PARKED.
REQ-023 An uninterrupted BLANK SHALL last exactly BLANK_CYCLES cycles.
REQ-024 The first routed word after BLANK SHALL be the dat_q of the cycle in which BLANK is exited.
REQ-025 Out-of-range indices (13..15) SHALL never route data and SHALL never cause X propagation.
REQ-026 The la_oenb masking SHALL apply per bit with no latency difference from data.

Reset
REQ-027 When nrst=0 at a rising edge, the next state SHALL be BLANK with pending_sel=0, cnt=BLANK_CYCLES-1, and dat_q=0, sel_q=0.
REQ-028 When nrst=0 at a rising edge, the outputs SHALL be: all team_la_in=0, team_la_valid=0, active_sel=4'hF, switching=1, sel_changes=0.
REQ-029 Reset asserted mid-BLANK or mid-ACTIVE SHALL abandon the operation with no residual routed data on the cycle after the reset edge.
REQ-030 After reset release with la_sel held at 0, team 0 SHALL become ACTIVE after BLANK_CYCLES cycles.

Verification
REQ-031 Bench SHALL cover: reset, la_sel=0, la_oenb=0, la_data_in=128'hA5..A5 -> switching high for 4 cycles, then team_la_in[0]=A5..A5, team_la_valid=13'h0001, active_sel=0.
REQ-032 Bench SHALL cover: ACTIVE on 0, la_sel->7 -> outputs zero for 4 cycles, sel_changes=1, then team_la_valid=13'h0080 and team 0 output 0.
REQ-033 Bench SHALL cover: la_sel 3 then 5 two cycles later (during BLANK) -> cnt reloads, ACTIVE on 5 exactly 4 cycles after the second change, sel_changes=1.
REQ-034 Bench SHALL cover: la_sel=14 -> PARKED, active_sel=4'hF, all outputs 0; then la_sel=12 -> ACTIVE on 12 after BLANK.
REQ-035 Bench SHALL cover: ACTIVE on 2, la_oenb=128'hFFFF0000_..._0, data all-ones -> team_la_in[2] upper 16 bits 0, rest 1, 2-cycle latency.
REQ-036 Bench SHALL cover: randomized 60 trials comparing against a reference model, including nrst=0 pulses mid-ACTIVE -> all outputs 0 the following cycle.
